if_pc_gen: RTL and testbench



---
 rtl/if_pc_gen_pkg.sv | 24 ++
 rtl/if_pc_gen_if.sv | 33 +++
 rtl/if_pc_trace.sv | 58 +++++
 rtl/if_pc_gen.sv | 145 ++++++++++++++
 tb/tb_if_pc_gen.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator, also used by the I$ and EX jump logic.
// Holds the word-address width, the FSM encoding and the trace entry layout.
package if_pc_gen_pkg;

  localparam int unsigned ADR_W = 30;

  typedef logic [ADR_W-1:0] word_adr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  typedef struct packed {
    word_adr_t src;
    word_adr_t dst;
  } trace_ent_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_pc_gen_if.sv
// Bundle between the CPU status / EX stage and the fetch PC generator.
// slave = PC generator side, master = the environment driving it.
interface if_pc_gen_if;
  import if_pc_gen_pkg::*;

  logic      pc_start;
  word_adr_t start_adr_lat;
  logic      stall;
  logic      ic_stall;
  logic      rst_pipe;
  logic      jmp_condition_ex;
  word_adr_t jmp_adr_ex;

  word_adr_t pc_if;
  logic      pc_valid_if;
  word_adr_t pc_id;
  logic      inst_valid_id;
  logic      flush_id;
  logic      redirect_pend;

  modport slave (
    input  pc_start, start_adr_lat, stall, ic_stall, rst_pipe,
           jmp_condition_ex, jmp_adr_ex,
    output pc_if, pc_valid_if, pc_id, inst_valid_id, flush_id, redirect_pend
  );

  modport master (
    output pc_start, start_adr_lat, stall, ic_stall, rst_pipe,
           jmp_condition_ex, jmp_adr_ex,
    input  pc_if, pc_valid_if, pc_id, inst_valid_id, flush_id, redirect_pend
  );

endinterface

// File: rtl/if_pc_trace.sv
// Circular history of applied redirects {source pc_id, target}; exists only with IF_PC_TRACE_EN.
// trace_sel = 0 reads the newest entry, 1 the one before it, and so on.
`ifdef IF_PC_TRACE_EN
module if_pc_trace
  import if_pc_gen_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rec_en,
  input  word_adr_t        rec_src,
  input  word_adr_t        rec_dst,
  input  logic [SEL_W-1:0] trace_sel,
  output word_adr_t        trace_src,
  output word_adr_t        trace_dst,
  output logic [7:0]       trace_cnt
);

  trace_ent_t       ent_q [DEPTH];
  trace_ent_t       ent_d [DEPTH];
  logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SEL_W-1:0] rd_idx;
  logic [7:0]       cnt_q, cnt_d;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (rec_en) begin
      ent_d[wr_ptr_q] = '{src: rec_src, dst: rec_dst};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: the history is tiny and must read back as zeros after rst_n, so it is
  // reset like ordinary flops instead of being left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_idx    = wr_ptr_q - trace_sel - SEL_W'(1);
  assign trace_src = ent_q[rd_idx].src;
  assign trace_dst = ent_q[rd_idx].dst;
  assign trace_cnt = cnt_q;

endmodule
`endif

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: start/flush handling, EX redirects (incl. ones caught during a stall).
// Optional redirect history enabled by defining IF_PC_TRACE_EN; default build has no trace ports.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter word_adr_t   RESET_PC    = 30'h0000_0000,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef IF_PC_TRACE_EN
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_sel,
  output word_adr_t                      trace_src,
  output word_adr_t                      trace_dst,
  output logic [7:0]                     trace_cnt,
`endif
  if_pc_gen_if.slave bus
);

  if (!is_pow2(TRACE_DEPTH)) begin : g_bad_trace_depth
    $error("if_pc_gen: TRACE_DEPTH must be a power of two >= 2");
  end

  pc_state_e state_q, state_d;
  word_adr_t pc_if_q, pc_if_d;
  word_adr_t pc_id_q, pc_id_d;
  word_adr_t pend_adr_q, pend_adr_d;
  logic      pc_valid_q, pc_valid_d;
  logic      inst_valid_q, inst_valid_d;
  logic      flush_q, flush_d;
  logic      pend_q, pend_d;
  logic      hold;

  assign hold = bus.stall | bus.ic_stall;

  // NOTE: every *_d gets its current value first so no path through the
  // priority chain below can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_if_d      = pc_if_q;
    pc_id_d      = pc_id_q;
    pend_adr_d   = pend_adr_q;
    pc_valid_d   = pc_valid_q;
    inst_valid_d = inst_valid_q;
    flush_d      = 1'b0;
    pend_d       = pend_q;

    // The fetch slot leaving IF dies if EX redirects now or a redirect is waiting.
    if (!hold) begin
      pc_id_d      = pc_if_q;
      inst_valid_d = pc_valid_q & ~bus.jmp_condition_ex & ~pend_q;
    end

    if (bus.rst_pipe) begin
      state_d      = IDLE;
      pc_if_d      = RESET_PC;
      pc_id_d      = RESET_PC;
      pc_valid_d   = 1'b0;
      inst_valid_d = 1'b0;
      pend_d       = 1'b0;
      pend_adr_d   = '0;
    end else if (bus.pc_start) begin
      state_d    = RUN;
      pc_if_d    = bus.start_adr_lat;
      pc_valid_d = 1'b1;
      pend_d     = 1'b0;
      pend_adr_d = '0;
    end else begin
      case (state_q)
        IDLE: pc_valid_d = 1'b0;
        RUN: begin
          if (bus.jmp_condition_ex && !hold) begin
            pc_if_d = bus.jmp_adr_ex;
            flush_d = 1'b1;
          end else if (bus.jmp_condition_ex) begin
            pend_adr_d = bus.jmp_adr_ex;
            pend_d     = 1'b1;
            state_d    = PEND;
          end else if (!hold) begin
            pc_if_d = pc_if_q + 30'd1;
          end
        end
        PEND: begin
          // A redirect arriving in the release cycle is younger than the stored one.
          if (!hold) begin
            pc_if_d = bus.jmp_condition_ex ? bus.jmp_adr_ex : pend_adr_q;
            flush_d = 1'b1;
            pend_d  = 1'b0;
            state_d = RUN;
          end else if (bus.jmp_condition_ex) begin
            pend_adr_d = bus.jmp_adr_ex;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_if_q      <= RESET_PC;
      pc_id_q      <= RESET_PC;
      pend_adr_q   <= '0;
      pc_valid_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_if_q      <= pc_if_d;
      pc_id_q      <= pc_id_d;
      pend_adr_q   <= pend_adr_d;
      pc_valid_q   <= pc_valid_d;
      inst_valid_q <= inst_valid_d;
      flush_q      <= flush_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.pc_if         = pc_if_q;
  assign bus.pc_valid_if   = pc_valid_q;
  assign bus.pc_id         = pc_id_q;
  assign bus.inst_valid_id = inst_valid_q;
  assign bus.flush_id      = flush_q;
  assign bus.redirect_pend = pend_q;

`ifdef IF_PC_TRACE_EN
  // The flush_id cycle is exactly when a redirect has been applied.
  if_pc_trace #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_en    (flush_q),
    .rec_src   (pc_id_q),
    .rec_dst   (pc_if_q),
    .trace_sel (trace_sel),
    .trace_src (trace_src),
    .trace_dst (trace_dst),
    .trace_cnt (trace_cnt)
  );
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: a spec-level reference model predicts each cycle's outputs,
// a separate monitor compares them; directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  localparam word_adr_t   RESET_PC    = 30'h0000_0000;
  localparam int unsigned TRACE_DEPTH = 4;

  typedef struct packed {
    word_adr_t pc_if;
    logic      pc_valid_if;
    word_adr_t pc_id;
    logic      inst_valid_id;
    logic      flush_id;
    logic      redirect_pend;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  if_pc_gen_if bus();

`ifdef IF_PC_TRACE_EN
  logic [1:0] trace_sel = 2'd0;
  word_adr_t  trace_src, trace_dst;
  logic [7:0] trace_cnt;
  trace_ent_t m_trace[$];
  int         m_trace_cnt;
`endif

  if_pc_gen #(.RESET_PC(RESET_PC), .TRACE_DEPTH(TRACE_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef IF_PC_TRACE_EN
    .trace_sel (trace_sel),
    .trace_src (trace_src),
    .trace_dst (trace_dst),
    .trace_cnt (trace_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: fetch address, ID slot, "running" and "redirect waiting" flags.
  word_adr_t m_fetch, m_id, m_target;
  bit        m_fvalid, m_idvalid, m_flush, m_running, m_pending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    return '{bus.pc_if, bus.pc_valid_if, bus.pc_id, bus.inst_valid_id,
             bus.flush_id, bus.redirect_pend};
  endfunction

  function automatic obs_t model_obs();
    return '{m_fetch, m_fvalid, m_id, m_idvalid, m_flush, m_pending};
  endfunction

  task automatic model_reset();
    m_fetch = RESET_PC; m_id = RESET_PC; m_target = '0;
    m_fvalid = 0; m_idvalid = 0; m_flush = 0; m_running = 0; m_pending = 0;
`ifdef IF_PC_TRACE_EN
    m_trace.delete();
    for (int k = 0; k < TRACE_DEPTH; k++) m_trace.push_back('0);
    m_trace_cnt = 0;
`endif
  endtask

  task automatic model_step(input bit rp, ps, input word_adr_t sa,
                            input bit st, ic, jc, input word_adr_t ja);
    bit         hold, nfv, niv, nfl, nrun, npend;
    word_adr_t  nf, ni, ntgt;
    trace_ent_t te;
    hold = st | ic;
`ifdef IF_PC_TRACE_EN
    if (m_flush) begin
      te.src = m_id;
      te.dst = m_fetch;
      m_trace.push_back(te);
      void'(m_trace.pop_front());
      if (m_trace_cnt < 255) m_trace_cnt++;
    end
`endif
    nf = m_fetch; nfv = m_fvalid; ni = m_id; niv = m_idvalid;
    nfl = 0; nrun = m_running; npend = m_pending; ntgt = m_target;
    if (!hold) begin
      ni  = m_fetch;
      niv = m_fvalid && !jc && !m_pending;
    end
    if (rp) begin
      nf = RESET_PC; ni = RESET_PC; nfv = 0; niv = 0; nrun = 0; npend = 0;
    end else if (ps) begin
      nf = sa; nfv = 1; nrun = 1; npend = 0;
    end else if (m_pending) begin
      if (!hold) begin
        nf = jc ? ja : m_target; nfl = 1; npend = 0;
      end else if (jc) begin
        ntgt = ja;
      end
    end else if (m_running) begin
      if (jc && !hold) begin
        nf = ja; nfl = 1;
      end else if (jc) begin
        ntgt = ja; npend = 1;
      end else if (!hold) begin
        nf = word_adr_t'((64'(m_fetch) + 64'd1) % (64'd1 << 30));
      end
    end
    m_fetch = nf; m_fvalid = nfv; m_id = ni; m_idvalid = niv;
    m_flush = nfl; m_running = nrun; m_pending = npend; m_target = ntgt;
  endtask

  task automatic set_inputs(input bit rp, ps, input word_adr_t sa,
                            input bit st, ic, jc, input word_adr_t ja);
    bus.rst_pipe = rp; bus.pc_start = ps; bus.start_adr_lat = sa;
    bus.stall = st; bus.ic_stall = ic; bus.jmp_condition_ex = jc; bus.jmp_adr_ex = ja;
  endtask

  // Called at a negedge: drive, predict, queue the expectation, then wait one cycle.
  task automatic cycle(input bit rp, ps, input word_adr_t sa,
                       input bit st, ic, jc, input word_adr_t ja);
    set_inputs(rp, ps, sa, st, ic, jc, ja);
    model_step(rp, ps, sa, st, ic, jc, ja);
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, 0, '0);
  endtask

`ifdef IF_PC_TRACE_EN
  task automatic check_trace();
    check("trace_cnt", 64'(trace_cnt), 64'(m_trace_cnt));
    for (int k = 0; k < TRACE_DEPTH; k++) begin
      trace_sel = 2'(k);
      #1;
      check("trace_src", 64'(trace_src), 64'(m_trace[TRACE_DEPTH-1-k].src));
      check("trace_dst", 64'(trace_dst), 64'(m_trace[TRACE_DEPTH-1-k].dst));
    end
  endtask
`endif

  // Monitor: the DUT presents a new output word after every edge.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", dut_obs(), e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit        rp, ps, st, ic, jc;
    word_adr_t sa, ja;

    set_inputs(0, 0, '0, 0, 0, 0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_obs(), model_obs());
    rst_n = 1'b1;

    // Start and sequential fetch
    cycle(0, 1, 30'h100, 0, 0, 0, '0);
    check("start_pc", bus.pc_if, 30'h100);
    check("start_valid", bus.pc_valid_if, 1);
    idle();
    check("inc1_pc", bus.pc_if, 30'h101);
    check("id_lag", bus.pc_id, 30'h100);
    idle();
    check("inc2_pc", bus.pc_if, 30'h102);
    check("id_valid", bus.inst_valid_id, 1);

    // Unstalled redirect
    cycle(0, 0, '0, 0, 0, 1, 30'h200);
    check("jmp_pc", bus.pc_if, 30'h200);
    check("jmp_flush", bus.flush_id, 1);
    check("jmp_kill", bus.inst_valid_id, 0);
    idle();
    check("jmp_flush_once", bus.flush_id, 0);
    check("jmp_inc", bus.pc_if, 30'h201);

    // Redirects captured during an I$ stall, youngest wins
    cycle(0, 0, '0, 0, 1, 1, 30'h300);
    check("pend_set", bus.redirect_pend, 1);
    check("pend_hold", bus.pc_if, 30'h201);
    cycle(0, 0, '0, 0, 1, 1, 30'h340);
    cycle(0, 0, '0, 0, 1, 0, '0);
    check("pend_hold3", bus.pc_if, 30'h201);
    idle();
    check("pend_apply", bus.pc_if, 30'h340);
    check("pend_flush", bus.flush_id, 1);
    check("pend_clear", bus.redirect_pend, 0);
    idle();
    check("pend_flush_once", bus.flush_id, 0);

    // Redirect in the release cycle overrides the stored target
    cycle(0, 0, '0, 1, 0, 1, 30'h400);
    cycle(0, 0, '0, 0, 0, 1, 30'h480);
    check("release_jmp", bus.pc_if, 30'h480);

    // rst_pipe beats pc_start
    cycle(1, 1, 30'h500, 0, 0, 0, '0);
    check("rp_pc", bus.pc_if, RESET_PC);
    check("rp_pc_id", bus.pc_id, RESET_PC);
    check("rp_valid_if", bus.pc_valid_if, 0);
    check("rp_valid_id", bus.inst_valid_id, 0);
    idle();
    check("idle_invalid", bus.pc_valid_if, 0);
    cycle(0, 1, 30'h600, 0, 0, 0, '0);
    check("restart_pc", bus.pc_if, 30'h600);

    // 30-bit wrap
    cycle(0, 1, 30'h3FFF_FFFE, 0, 0, 0, '0);
    idle();
    check("wrap_top", bus.pc_if, 30'h3FFF_FFFF);
    idle();
    check("wrap_zero", bus.pc_if, 30'h0);

    // Async reset while a redirect is pending
    cycle(0, 0, '0, 1, 0, 1, 30'h700);
    check("pre_rst_pend", bus.redirect_pend, 1);
    set_inputs(0, 0, '0, 0, 0, 0, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst", dut_obs(), model_obs());
`ifdef IF_PC_TRACE_EN
    check("async_rst_trace", 64'(trace_cnt), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post_rst_pend", bus.redirect_pend, 0);

    // Five redirects into a four-entry history
    cycle(0, 1, 30'h1000, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, 0, 0, 1, 30'h2000 + word_adr_t'(i * 16));
      idle();
    end
`ifdef IF_PC_TRACE_EN
    check("trace_cnt5", 64'(trace_cnt), 5);
    check_trace();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rp = ($urandom_range(63) == 0);
      ps = ($urandom_range(31) == 0);
      sa = ($urandom_range(3) == 0) ? (30'h3FFF_FFF0 | word_adr_t'($urandom_range(15)))
                                    : word_adr_t'($urandom);
      st = ($urandom_range(5) == 0);
      ic = ($urandom_range(4) == 0);
      jc = ($urandom_range(6) == 0);
      ja = word_adr_t'($urandom);
      cycle(rp, ps, sa, st, ic, jc, ja);
    end
    idle();
`ifdef IF_PC_TRACE_EN
    check_trace();
`endif
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
